// File: rtl/axi_lite_rd_sequencer.sv
// AXI4-Lite read master: walks a (addr, count, stride) descriptor with up to MAX_OUT
// single-beat reads in flight and forwards R beats on a ready/valid stream.
module axi_lite_rd_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int MAX_OUT     = 4,
    parameter int STOP_ON_ERR = 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [ADDR_W-1:0] cmd_stride,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_resp,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int   OUT_W = 4;
    localparam logic STOP  = (STOP_ON_ERR != 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  returned_q, returned_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic active, ar_hs, r_hs, r_bad, ar_pend, can_issue, err_now;

    assign active        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign cmd_ready     = (state_q == S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rd_ready && active;
    assign rd_valid      = M_AXI_RVALID && active;
    assign rd_data       = M_AXI_RDATA;
    assign rd_resp       = M_AXI_RRESP;

    assign ar_hs   = arvalid_q && M_AXI_ARREADY;
    assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;
    assign r_bad   = (M_AXI_RRESP != 2'b00);
    assign ar_pend = arvalid_q && !M_AXI_ARREADY;
    assign err_now = err_q || (rd_valid && r_bad);

    // After an error stop the last beat is the one that empties the pipe with no AR pending.
    assign rd_last = active && ((returned_q == count_q - CNT_W'(1)) ||
                     (STOP && err_now && (outst_q == OUT_W'(1)) && !arvalid_q));

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        count_d    = count_q;
        stride_d   = stride_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        issued_d   = issued_q + CNT_W'(ar_hs);
        returned_d = returned_q + CNT_W'(r_hs);
        outst_d    = outst_q + OUT_W'(ar_hs) - OUT_W'(r_hs);

        if (r_hs && r_bad) begin
            err_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (ar_hs) araddr_d = araddr_q + stride_q;

        // Decided on post-handshake counts so a freed slot is reused the very next cycle.
        can_issue = (state_q == S_RUN) && (issued_d < count_q) &&
                    (outst_d < OUT_W'(MAX_OUT)) && !(STOP && err_d);
        arvalid_d = ar_pend || can_issue;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    araddr_d   = cmd_addr;
                    count_d    = cmd_count;
                    stride_d   = cmd_stride;
                    err_d      = 1'b0;
                    err_cnt_d  = '0;
                    issued_d   = '0;
                    returned_d = '0;
                    outst_d    = '0;
                    if (cmd_count == '0) begin
                        state_d   = S_DONE;
                        arvalid_d = 1'b0;
                    end else begin
                        state_d   = S_RUN;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!ar_pend && ((issued_d == count_q) || (STOP && err_d))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (outst_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            count_q    <= '0;
            stride_q   <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            count_q    <= count_d;
            stride_q   <= stride_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
